mem_access_stage: RTL and testbench
===================================

Name: mem_access_stage

Overview:
- Pipeline stage between the ALU stage and the writeback unit.
- Non-memory results pass straight through to writeback.
- Loads and stores drive a data-RAM request/ready handshake; the stage stalls upstream until the access completes.
- Loads are formatted (byte/half/word, sign or zero extension) before being handed to writeback.

Parameters:
- ADDR_W, 16, data-RAM byte-address width; mem_addr carries bits [ADDR_W-1:2] with [1:0] forced to 0.
- MAX_WAIT, 255, maximum cycles to wait for mem_ready before the access is abandoned.

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  ALU result/command valid.
- in_ready  out  1  stage can accept a command this cycle (stall = !in_ready).
- in_op  in  4  mem_op_e: NONE, LB, LH, LW, LBU, LHU, SB, SH, SW.
- in_alu_result  in  32  ALU result; used as the effective address for memory ops.
- in_store_data  in  32  rs2 value for stores.
- in_rd_addr  in  5  destination register.
- mem_req  out  1  RAM request.
- mem_we  out  1  1 = write.
- mem_addr  out  ADDR_W  word-aligned byte address.
- mem_wstrb  out  4  byte-lane write enables.
- mem_wdata  out  32  lane-shifted store data.
- mem_ready  in  1  RAM accepted the request (writes) or returned data (reads).
- mem_rdata  in  32  read data, valid while mem_ready=1.
- wb_valid  out  1  writeback record valid.
- wb_wr_en  out  1  write the register file.
- wb_rd_addr  out  5  destination register.
- wb_data  out  32  result data.
- mem_fault  out  1  one-cycle pulse on timeout or misaligned access.

Behaviour:
- Reset value of every output is 0, except in_ready = 1. Reset mid-access drops mem_req immediately and returns the FSM to IDLE. The pending command is lost.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - in_ready = 1.
  - On in_valid with in_op = NONE: register the writeback record next cycle (wb_data = in_alu_result, wb_wr_en = (rd != 0)). Stay in IDLE. Latency is 1 and throughput is 1 per cycle.
  - On in_valid with a memory op: capture the command and go to ACCESS. mem_req rises in the cycle after acceptance.
- ACCESS:
  - in_ready = 0. mem_req = 1.
  - mem_addr, mem_we, mem_wstrb and mem_wdata stay stable until mem_ready.
  - The wait counter increments every cycle.
  - On mem_ready go to RESP. mem_req is low in the following cycle.
  - When the counter reaches MAX_WAIT: drop mem_req, pulse mem_fault, set wb_valid = 1 with wb_wr_en = 0, and go to IDLE.
- RESP:
  - wb_valid = 1 for exactly one cycle.
  - Loads: wb_data = formatted rdata, wb_wr_en = (rd != 0).
  - Stores: wb_wr_en = 0.
  - in_ready = 1 in this cycle, so a back-to-back command is accepted. Memory-op latency is 2 + wait cycles.
- Load formatting uses byte offset off = addr[1:0]:
  - LB/LBU select rdata[8*off+7 : 8*off]. LB sign-extends; LBU zero-extends.
  - LH/LHU select rdata[16*off[1]+15 : 16*off[1]]. LH sign-extends; LHU zero-extends.
  - LW uses rdata unchanged.
- Store lanes:
  - SB: wstrb = 1 << off; the data byte is replicated on all lanes.
  - SH: wstrb = 3 << off; the halfword is replicated.
  - SW: wstrb = 4'hF.
- Address bits above ADDR_W are ignored (wrap-around).
- wb_valid is 0 in every cycle not described above.

Optional Feature:
- Macro: MEM_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with off[0] = 1, or LW/SW with off != 0, issue no RAM request. The stage pulses mem_fault and emits wb_valid with wb_wr_en = 0 one cycle after acceptance.
- Undefined: the low offset bits are truncated (half uses off[1]; word uses offset 0) and the access proceeds normally. mem_fault then signals timeout only.

Decomposition:
- Package mem_stage_pkg holds:
  - mem_op_e enum (4-bit).
  - mem_state_e enum.
  - Helper functions is_load(), is_store(), op_size().
- One sub-module, load_formatter: combinational rdata/op/offset to 32-bit result. It is reused later by a data cache.

Test Plan:
- ALU passthrough: in_op = NONE, rd = 5, alu_result = 0x1234 -> next cycle wb_valid = 1, wb_wr_en = 1, wb_data = 0x1234; rd = 0 gives wb_wr_en = 0.
- LB sign extension: addr = 0x0102, rdata = 0x00800000, mem_ready after 3 wait cycles -> mem_addr = 0x0100, wb_data = 0xFFFFFF80. LBU on the same inputs gives 0x00000080.
- SH: addr = 0x0012, store_data = 0xABCD1234 -> mem_we = 1, wstrb = 4'b1100, wdata = 0x12341234, then wb_valid with wb_wr_en = 0.
- Back-to-back: LW issued, then NONE offered during ACCESS -> in_ready = 0 until the RESP cycle; NONE accepted in RESP and its wb_valid follows the next cycle.
- Timeout: mem_ready held low -> after MAX_WAIT cycles mem_req falls, mem_fault pulses once, FSM returns to IDLE. Reset asserted mid-ACCESS -> mem_req = 0 immediately.
- MEM_MISALIGN_TRAP_EN: LW at addr 0x0003 -> no mem_req, mem_fault = 1; without the macro, mem_addr = 0x0000 with a normal response.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types and helpers for the memory-access pipeline stage.
// Holds the memory-op encoding, the stage FSM states and small op decoders.
package mem_stage_pkg;

    typedef enum logic [3:0] {
        OP_NONE = 4'd0,
        OP_LB   = 4'd1,
        OP_LH   = 4'd2,
        OP_LW   = 4'd3,
        OP_LBU  = 4'd4,
        OP_LHU  = 4'd5,
        OP_SB   = 4'd6,
        OP_SH   = 4'd7,
        OP_SW   = 4'd8
    } mem_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } mem_state_e;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    function automatic logic is_load(input mem_op_e op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: is_load = 1'b1;
            default:                             is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input mem_op_e op);
        case (op)
            OP_SB, OP_SH, OP_SW: is_store = 1'b1;
            default:             is_store = 1'b0;
        endcase
    endfunction

    // Access width of an op; non-memory encodings report word size.
    function automatic logic [1:0] op_size(input mem_op_e op);
        case (op)
            OP_LB, OP_LBU, OP_SB: op_size = SIZE_BYTE;
            OP_LH, OP_LHU, OP_SH: op_size = SIZE_HALF;
            default:              op_size = SIZE_WORD;
        endcase
    endfunction

    // True when a memory op's byte offset does not match its natural alignment.
    function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] off);
        if (!(is_load(op) || is_store(op))) begin
            is_misaligned = 1'b0;
        end else begin
            case (op_size(op))
                SIZE_BYTE: is_misaligned = 1'b0;
                SIZE_HALF: is_misaligned = off[0];
                default:   is_misaligned = (off != 2'b00);
            endcase
        end
    endfunction

endpackage

// File: rtl/mem_access_stage_load_formatter.sv
// Combinational load-data formatter: picks the addressed byte/halfword out of a
// 32-bit read word and sign- or zero-extends it. Kept standalone so a data cache
// can reuse it on its own read path.
module load_formatter
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  mem_op_e     op_i,
    input  logic [1:0]  off_i,
    output logic [31:0] result_o
);

    logic [31:0] byteShifted;
    logic [31:0] halfShifted;
    logic [7:0]  byteSel;
    logic [15:0] halfSel;

    // Halfwords only look at off[1], so a stray off[0] simply truncates.
    always_comb begin
        byteShifted = rdata_i >> {off_i, 3'b000};
        halfShifted = rdata_i >> {off_i[1], 4'b0000};
        byteSel     = byteShifted[7:0];
        halfSel     = halfShifted[15:0];
        case (op_i)
            OP_LB:   result_o = {{24{byteSel[7]}}, byteSel};
            OP_LBU:  result_o = {24'd0, byteSel};
            OP_LH:   result_o = {{16{halfSel[15]}}, halfSel};
            OP_LHU:  result_o = {16'd0, halfSel};
            default: result_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage between the ALU and writeback.
// ALU results pass through in one cycle; loads/stores run a req/ready handshake
// to the data RAM, stalling upstream until the access completes or times out.
// Optional build macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses are
// rejected with a fault instead of being issued with truncated offsets.
module mem_access_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [31:0]       in_alu_result,
    input  logic [31:0]       in_store_data,
    input  logic [4:0]        in_rd_addr,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic [31:0]       mem_rdata,
    output logic              wb_valid,
    output logic              wb_wr_en,
    output logic [4:0]        wb_rd_addr,
    output logic [31:0]       wb_data,
    output logic              mem_fault
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    mem_state_e        state_q, state_d;
    mem_op_e           cmdOp_q, cmdOp_d;
    logic [1:0]        cmdOff_q, cmdOff_d;
    logic [4:0]        cmdRd_q, cmdRd_d;
    logic [ADDR_W-1:0] memAddr_q, memAddr_d;
    logic [3:0]        wstrb_q, wstrb_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [WAIT_W-1:0] waitCnt_q, waitCnt_d;
    logic              wbValid_q, wbValid_d;
    logic              wbWrEn_q, wbWrEn_d;
    logic [4:0]        wbRd_q, wbRd_d;
    logic [31:0]       wbData_q, wbData_d;
    logic              memFault_q, memFault_d;

    mem_op_e           inOp;
    logic [1:0]        inOff;
    logic              inIsMem;
    logic              inMisaligned;
    logic [3:0]        storeStrb;
    logic [31:0]       storeData;
    logic [31:0]       loadResult;
    logic              unusedAddrBits;

    assign inOp    = mem_op_e'(in_op);
    assign inOff   = in_alu_result[1:0];
    assign inIsMem = is_load(inOp) || is_store(inOp);

    // Address bits above the RAM width wrap around and are deliberately dropped.
    assign unusedAddrBits = ^in_alu_result[31:ADDR_W];

`ifdef MEM_MISALIGN_TRAP_EN
    assign inMisaligned = is_misaligned(inOp, inOff);
`else
    assign inMisaligned = 1'b0;
`endif

    // Store lane strobes and replicated write data; half/word offsets truncate.
    always_comb begin
        storeStrb = 4'b0000;
        storeData = in_store_data;
        if (is_store(inOp)) begin
            case (op_size(inOp))
                SIZE_BYTE: begin
                    storeStrb = 4'b0001 << inOff;
                    storeData = {4{in_store_data[7:0]}};
                end
                SIZE_HALF: begin
                    storeStrb = inOff[1] ? 4'b1100 : 4'b0011;
                    storeData = {2{in_store_data[15:0]}};
                end
                default: storeStrb = 4'b1111;
            endcase
        end
    end

    load_formatter u_load_formatter (
        .rdata_i  (mem_rdata),
        .op_i     (cmdOp_q),
        .off_i    (cmdOff_q),
        .result_o (loadResult)
    );

    // Next-state and writeback-record logic; only ACCESS refuses new commands.
    always_comb begin
        state_d    = state_q;
        cmdOp_d    = cmdOp_q;
        cmdOff_d   = cmdOff_q;
        cmdRd_d    = cmdRd_q;
        memAddr_d  = memAddr_q;
        wstrb_d    = wstrb_q;
        wdata_d    = wdata_q;
        waitCnt_d  = waitCnt_q;
        wbValid_d  = 1'b0;
        wbWrEn_d   = 1'b0;
        wbRd_d     = wbRd_q;
        wbData_d   = wbData_q;
        memFault_d = 1'b0;
        case (state_q)
            ST_ACCESS: begin
                if (mem_ready) begin
                    state_d   = ST_RESP;
                    wbValid_d = 1'b1;
                    wbRd_d    = cmdRd_q;
                    if (is_load(cmdOp_q)) begin
                        wbWrEn_d = (cmdRd_q != 5'd0);
                        wbData_d = loadResult;
                    end
                end else if (waitCnt_q == WAIT_W'(MAX_WAIT - 1)) begin
                    state_d    = ST_IDLE;
                    waitCnt_d  = '0;
                    wbValid_d  = 1'b1;
                    wbRd_d     = cmdRd_q;
                    memFault_d = 1'b1;
                end else begin
                    waitCnt_d = waitCnt_q + WAIT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                if (in_valid) begin
                    if (!inIsMem) begin
                        wbValid_d = 1'b1;
                        wbWrEn_d  = (in_rd_addr != 5'd0);
                        wbRd_d    = in_rd_addr;
                        wbData_d  = in_alu_result;
                    end else if (inMisaligned) begin
                        wbValid_d  = 1'b1;
                        wbRd_d     = in_rd_addr;
                        memFault_d = 1'b1;
                    end else begin
                        state_d   = ST_ACCESS;
                        cmdOp_d   = inOp;
                        cmdOff_d  = inOff;
                        cmdRd_d   = in_rd_addr;
                        memAddr_d = {in_alu_result[ADDR_W-1:2], 2'b00};
                        wstrb_d   = storeStrb;
                        wdata_d   = storeData;
                        waitCnt_d = '0;
                    end
                end
            end
        endcase
    end

    // State, captured command and writeback registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cmdOp_q    <= OP_NONE;
            cmdOff_q   <= 2'b00;
            cmdRd_q    <= 5'd0;
            memAddr_q  <= '0;
            wstrb_q    <= 4'b0000;
            wdata_q    <= 32'd0;
            waitCnt_q  <= '0;
            wbValid_q  <= 1'b0;
            wbWrEn_q   <= 1'b0;
            wbRd_q     <= 5'd0;
            wbData_q   <= 32'd0;
            memFault_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cmdOp_q    <= cmdOp_d;
            cmdOff_q   <= cmdOff_d;
            cmdRd_q    <= cmdRd_d;
            memAddr_q  <= memAddr_d;
            wstrb_q    <= wstrb_d;
            wdata_q    <= wdata_d;
            waitCnt_q  <= waitCnt_d;
            wbValid_q  <= wbValid_d;
            wbWrEn_q   <= wbWrEn_d;
            wbRd_q     <= wbRd_d;
            wbData_q   <= wbData_d;
            memFault_q <= memFault_d;
        end
    end

    // Request is decoded from state so an async reset drops it immediately.
    assign in_ready   = (state_q != ST_ACCESS);
    assign mem_req    = (state_q == ST_ACCESS);
    assign mem_we     = mem_req && is_store(cmdOp_q);
    assign mem_wstrb  = mem_we ? wstrb_q : 4'b0000;
    assign mem_addr   = memAddr_q;
    assign mem_wdata  = wdata_q;
    assign wb_valid   = wbValid_q;
    assign wb_wr_en   = wbWrEn_q;
    assign wb_rd_addr = wbRd_q;
    assign wb_data    = wbData_q;
    assign mem_fault  = memFault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: a scoreboard queue holds expected
// writeback records, pushed when a command is driven and popped by a monitor.
module tb_mem_access_stage;
    import mem_stage_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int MAX_WAIT = 255;

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_op;
    logic [31:0]       in_alu_result;
    logic [31:0]       in_store_data;
    logic [4:0]        in_rd_addr;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [3:0]        mem_wstrb;
    logic [31:0]       mem_wdata;
    logic              mem_ready;
    logic [31:0]       mem_rdata;
    logic              wb_valid;
    logic              wb_wr_en;
    logic [4:0]        wb_rd_addr;
    logic [31:0]       wb_data;
    logic              mem_fault;

    typedef struct packed {
        logic        fault;
        logic        wrEn;
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_exp_t;

    wb_exp_t sb[$];
    wb_exp_t monExp;
    int      assertCount;
    int      failCount;

    mem_access_stage #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_op         (in_op),
        .in_alu_result (in_alu_result),
        .in_store_data (in_store_data),
        .in_rd_addr    (in_rd_addr),
        .mem_req       (mem_req),
        .mem_we        (mem_we),
        .mem_addr      (mem_addr),
        .mem_wstrb     (mem_wstrb),
        .mem_wdata     (mem_wdata),
        .mem_ready     (mem_ready),
        .mem_rdata     (mem_rdata),
        .wb_valid      (wb_valid),
        .wb_wr_en      (wb_wr_en),
        .wb_rd_addr    (wb_rd_addr),
        .wb_data       (wb_data),
        .mem_fault     (mem_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference load formatting built directly from the byte-lane rules.
    function automatic logic [31:0] expLoad(input mem_op_e op, input logic [31:0] addr,
                                            input logic [31:0] rdata);
        logic [7:0]  b;
        logic [15:0] h;
        case (addr[1:0])
            2'd0:    b = rdata[7:0];
            2'd1:    b = rdata[15:8];
            2'd2:    b = rdata[23:16];
            default: b = rdata[31:24];
        endcase
        h = addr[1] ? rdata[31:16] : rdata[15:0];
        case (op)
            OP_LB:   return {{24{b[7]}}, b};
            OP_LBU:  return {24'd0, b};
            OP_LH:   return {{16{h[15]}}, h};
            OP_LHU:  return {16'd0, h};
            default: return rdata;
        endcase
    endfunction

    function automatic logic [3:0] expStrb(input mem_op_e op, input logic [31:0] addr);
        case (op)
            OP_SB: case (addr[1:0])
                       2'd0:    return 4'b0001;
                       2'd1:    return 4'b0010;
                       2'd2:    return 4'b0100;
                       default: return 4'b1000;
                   endcase
            OP_SH:   return addr[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] expWdata(input mem_op_e op, input logic [31:0] sd);
        case (op)
            OP_SB:   return {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            OP_SH:   return {sd[15:0], sd[15:0]};
            default: return sd;
        endcase
    endfunction

    // Writeback monitor: every wb_valid must match the oldest expected record.
    always @(negedge clk) begin
        if (!reset) begin
            if (wb_valid) begin
                assertCount++;
                if (sb.size() == 0) begin
                    failCount++;
                    $display("[TB] FAIL wb_unexpected: got wb_valid=1 rd=%0d data=%h, required no record",
                             wb_rd_addr, wb_data);
                end else begin
                    monExp = sb.pop_front();
                    if (wb_wr_en !== monExp.wrEn || mem_fault !== monExp.fault ||
                        (monExp.wrEn && (wb_rd_addr !== monExp.rd || wb_data !== monExp.data))) begin
                        failCount++;
                        $display("[TB] FAIL wb_record: got wr_en=%b fault=%b rd=%0d data=%h, required wr_en=%b fault=%b rd=%0d data=%h",
                                 wb_wr_en, mem_fault, wb_rd_addr, wb_data,
                                 monExp.wrEn, monExp.fault, monExp.rd, monExp.data);
                    end
                end
            end else if (mem_fault) begin
                assertCount++;
                failCount++;
                $display("[TB] FAIL fault_alone: got mem_fault=1 wb_valid=0, required fault only with wb_valid");
            end
        end
    end

    // Drives one memory op through the handshake and reports what the RAM side saw.
    task automatic applyMemOp(input mem_op_e op, input logic [31:0] addr, input logic [31:0] sd,
                              input logic [4:0] rd, input int waits, input logic [31:0] rdata,
                              output logic [ADDR_W-1:0] oAddr, output logic oWe,
                              output logic [3:0] oStrb, output logic [31:0] oData,
                              output int oReqCycles, output logic oStable);
        wb_exp_t e;
        @(negedge clk);
        in_valid      = 1'b1;
        in_op         = op;
        in_alu_result = addr;
        in_store_data = sd;
        in_rd_addr    = rd;
        e.fault = 1'b0;
        e.wrEn  = is_load(op) && (rd != 5'd0);
        e.rd    = rd;
        e.data  = expLoad(op, addr, rdata);
        sb.push_back(e);
        @(negedge clk);
        in_valid   = 1'b0;
        oAddr      = mem_addr;
        oWe        = mem_we;
        oStrb      = mem_wstrb;
        oData      = mem_wdata;
        oReqCycles = 0;
        oStable    = 1'b1;
        for (int i = 0; i <= waits; i++) begin
            if (i > 0) @(negedge clk);
            if (mem_req === 1'b1) oReqCycles++;
            if (in_ready !== 1'b0 || mem_addr !== oAddr || mem_we !== oWe ||
                mem_wstrb !== oStrb || mem_wdata !== oData) oStable = 1'b0;
            if (i == waits) begin
                mem_ready = 1'b1;
                mem_rdata = rdata;
            end
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        if (mem_req === 1'b1) oReqCycles++;
    endtask

    task automatic test_reset();
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 ||
            mem_wstrb !== 4'd0 || mem_wdata !== 32'd0) begin
            failCount++;
            $display("[TB] FAIL reset_mem_side: got ready=%b req=%b we=%b addr=%h strb=%b wdata=%h, required 1 0 0 0 0 0",
                     in_ready, mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata);
        end
        assertCount++;
        if (wb_valid !== 1'b0 || wb_wr_en !== 1'b0 || wb_rd_addr !== 5'd0 ||
            wb_data !== 32'd0 || mem_fault !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_wb_side: got valid=%b wr_en=%b rd=%0d data=%h fault=%b, required all 0",
                     wb_valid, wb_wr_en, wb_rd_addr, wb_data, mem_fault);
        end
        reset = 1'b0;
        @(negedge clk);
        assertCount++;
        if (in_ready !== 1'b1 || mem_req !== 1'b0 || wb_valid !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_release_idle: got ready=%b req=%b wb_valid=%b, required 1 0 0",
                     in_ready, mem_req, wb_valid);
        end
    endtask

    task automatic test_passthrough();
        wb_exp_t e;
        int      readyOk;
        readyOk = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (in_ready !== 1'b1) readyOk = 0;
            in_valid = 1'b1;
            in_op    = OP_NONE;
            case (i)
                0:       begin in_rd_addr = 5'd5; in_alu_result = 32'h00001234; end
                1:       begin in_rd_addr = 5'd0; in_alu_result = 32'h0000BEEF; end
                default: begin
                    in_rd_addr    = 5'($urandom_range(1, 31));
                    in_alu_result = $urandom;
                end
            endcase
            e.fault = 1'b0;
            e.wrEn  = (in_rd_addr != 5'd0);
            e.rd    = in_rd_addr;
            e.data  = in_alu_result;
            sb.push_back(e);
        end
        @(negedge clk);
        in_valid = 1'b0;
        assertCount++;
        if (readyOk != 1) begin
            failCount++;
            $display("[TB] FAIL pass_ready: got in_ready low during passthrough, required 1");
        end
        @(negedge clk);
        assertCount++;
        if (sb.size() != 0) begin
            failCount++;
            $display("[TB] FAIL pass_latency: got %0d records outstanding, required 0", sb.size());
        end
    endtask

    task automatic test_loads();
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [3:0]        st;
        logic [31:0]       wd;
        int                rc;
        logic              stable;
        applyMemOp(OP_LB, 32'h00000102, 32'd0, 5'd6, 3, 32'h00800000, a, we, st, wd, rc, stable);
        assertCount++;
        if (a !== 16'h0100 || we !== 1'b0 || rc != 4 || stable !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL lb_request: got addr=%h we=%b req_cycles=%0d stable=%b, required 0100 0 4 1",
                     a, we, rc, stable);
        end
        applyMemOp(OP_LBU, 32'h00000102, 32'd0, 5'd7, 3, 32'h00800000, a, we, st, wd, rc, stable);
        assertCount++;
        if (a !== 16'h0100 || rc != 4 || stable !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL lbu_request: got addr=%h req_cycles=%0d stable=%b, required 0100 4 1",
                     a, rc, stable);
        end
        applyMemOp(OP_LH, 32'h00000202, 32'd0, 5'd8, 0, 32'h80017FFF, a, we, st, wd, rc, stable);
        applyMemOp(OP_LHU, 32'h00000200, 32'd0, 5'd9, 1, 32'h80017FFF, a, we, st, wd, rc, stable);
        applyMemOp(OP_LB, 32'h00000303, 32'd0, 5'd10, 2, 32'h7F000000, a, we, st, wd, rc, stable);
        applyMemOp(OP_LW, 32'h00010204, 32'd0, 5'd11, 0, 32'hCAFEF00D, a, we, st, wd, rc, stable);
        assertCount++;
        if (a !== 16'h0204 || rc != 1) begin
            failCount++;
            $display("[TB] FAIL addr_wrap: got addr=%h req_cycles=%0d, required 0204 1", a, rc);
        end
        applyMemOp(OP_LW, 32'h00000400, 32'd0, 5'd0, 0, 32'h11111111, a, we, st, wd, rc, stable);
    endtask

    task automatic test_stores();
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [3:0]        st;
        logic [31:0]       wd;
        int                rc;
        logic              stable;
        applyMemOp(OP_SH, 32'h00000012, 32'hABCD1234, 5'd3, 0, 32'h0, a, we, st, wd, rc, stable);
        assertCount++;
        if (a !== 16'h0010 || we !== 1'b1 || st !== 4'b1100 || wd !== 32'h12341234) begin
            failCount++;
            $display("[TB] FAIL sh_lanes: got addr=%h we=%b strb=%b wdata=%h, required 0010 1 1100 12341234",
                     a, we, st, wd);
        end
        for (int i = 0; i < 4; i++) begin
            mem_op_e     op;
            logic [31:0] ad;
            logic [31:0] sd;
            op = (i == 3) ? OP_SW : ((i == 2) ? OP_SH : OP_SB);
            ad = {20'd0, 8'h20 + 8'(i * 4), 2'b00, 2'(i)};
            if (op == OP_SH) ad[0] = 1'b0;
            if (op == OP_SW) ad[1:0] = 2'b00;
            sd = $urandom;
            applyMemOp(op, ad, sd, 5'(i + 1), i, 32'h0, a, we, st, wd, rc, stable);
            assertCount++;
            if (we !== 1'b1 || st !== expStrb(op, ad) || wd !== expWdata(op, sd) ||
                a !== {ad[ADDR_W-1:2], 2'b00} || rc != i + 1 || stable !== 1'b1) begin
                failCount++;
                $display("[TB] FAIL store_lanes_%0d: got we=%b strb=%b wdata=%h addr=%h req_cycles=%0d stable=%b, required 1 %b %h %h %0d 1",
                         i, we, st, wd, a, rc, stable, expStrb(op, ad), expWdata(op, sd),
                         {ad[ADDR_W-1:2], 2'b00}, i + 1);
            end
        end
    endtask

    task automatic test_back_to_back();
        wb_exp_t e;
        int      stallOk;
        @(negedge clk);
        in_valid      = 1'b1;
        in_op         = OP_LW;
        in_alu_result = 32'h00000208;
        in_rd_addr    = 5'd3;
        e.fault = 1'b0; e.wrEn = 1'b1; e.rd = 5'd3; e.data = 32'h13579BDF;
        sb.push_back(e);
        @(negedge clk);
        in_op         = OP_NONE;
        in_alu_result = 32'h00000777;
        in_rd_addr    = 5'd4;
        stallOk = 1;
        for (int i = 0; i < 3; i++) begin
            if (i > 0) @(negedge clk);
            if (in_ready !== 1'b0) stallOk = 0;
            if (i == 2) begin
                mem_ready = 1'b1;
                mem_rdata = 32'h13579BDF;
            end
        end
        assertCount++;
        if (stallOk != 1) begin
            failCount++;
            $display("[TB] FAIL b2b_stall: got in_ready=1 during ACCESS, required 0");
        end
        @(negedge clk);
        mem_ready = 1'b0;
        mem_rdata = 32'hDEADBEEF;
        assertCount++;
        if (in_ready !== 1'b1 || wb_valid !== 1'b1 || mem_req !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL b2b_resp: got ready=%b wb_valid=%b req=%b, required 1 1 0",
                     in_ready, wb_valid, mem_req);
        end
        e.fault = 1'b0; e.wrEn = 1'b1; e.rd = 5'd4; e.data = 32'h00000777;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        assertCount++;
        if (wb_valid !== 1'b1 || wb_data !== 32'h00000777) begin
            failCount++;
            $display("[TB] FAIL b2b_follow: got wb_valid=%b data=%h, required 1 00000777", wb_valid, wb_data);
        end
    endtask

    task automatic test_timeout();
        wb_exp_t e;
        int      reqCycles;
        int      guard;
        @(negedge clk);
        in_valid      = 1'b1;
        in_op         = OP_LW;
        in_alu_result = 32'h00000040;
        in_rd_addr    = 5'd9;
        e.fault = 1'b1; e.wrEn = 1'b0; e.rd = 5'd9; e.data = 32'd0;
        sb.push_back(e);
        @(negedge clk);
        in_valid  = 1'b0;
        reqCycles = 0;
        guard     = 0;
        while (mem_req === 1'b1 && guard < 1000) begin
            reqCycles++;
            guard++;
            @(negedge clk);
        end
        assertCount++;
        if (reqCycles != MAX_WAIT) begin
            failCount++;
            $display("[TB] FAIL timeout_cycles: got mem_req high %0d cycles, required %0d", reqCycles, MAX_WAIT);
        end
        assertCount++;
        if (mem_fault !== 1'b1 || wb_valid !== 1'b1 || in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL timeout_fault: got fault=%b wb_valid=%b ready=%b, required 1 1 1",
                     mem_fault, wb_valid, in_ready);
        end
        @(negedge clk);
        assertCount++;
        if (mem_fault !== 1'b0 || wb_valid !== 1'b0 || mem_req !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL timeout_pulse: got fault=%b wb_valid=%b req=%b, required 0 0 0",
                     mem_fault, wb_valid, mem_req);
        end
    endtask

    task automatic test_reset_mid_access();
        @(negedge clk);
        in_valid      = 1'b1;
        in_op         = OP_SW;
        in_alu_result = 32'h00000080;
        in_store_data = 32'h55AA55AA;
        in_rd_addr    = 5'd12;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        assertCount++;
        if (mem_req !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL mid_reset_pre: got mem_req=%b, required 1", mem_req);
        end
        #2;
        reset = 1'b1;
        #1;
        assertCount++;
        if (mem_req !== 1'b0 || in_ready !== 1'b1 || mem_we !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL mid_reset_drop: got req=%b ready=%b we=%b, required 0 1 0",
                     mem_req, in_ready, mem_we);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        assertCount++;
        if (mem_req !== 1'b0 || wb_valid !== 1'b0 || sb.size() != 0) begin
            failCount++;
            $display("[TB] FAIL mid_reset_lost: got req=%b wb_valid=%b outstanding=%0d, required 0 0 0",
                     mem_req, wb_valid, sb.size());
        end
    endtask

    task automatic test_misalign();
`ifdef MEM_MISALIGN_TRAP_EN
        wb_exp_t e;
        @(negedge clk);
        in_valid      = 1'b1;
        in_op         = OP_LW;
        in_alu_result = 32'h00000003;
        in_rd_addr    = 5'd7;
        e.fault = 1'b1; e.wrEn = 1'b0; e.rd = 5'd7; e.data = 32'd0;
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b0;
        assertCount++;
        if (mem_req !== 1'b0 || mem_fault !== 1'b1 || wb_valid !== 1'b1 || in_ready !== 1'b1) begin
            failCount++;
            $display("[TB] FAIL misalign_trap: got req=%b fault=%b wb_valid=%b ready=%b, required 0 1 1 1",
                     mem_req, mem_fault, wb_valid, in_ready);
        end
`else
        logic [ADDR_W-1:0] a;
        logic              we;
        logic [3:0]        st;
        logic [31:0]       wd;
        int                rc;
        logic              stable;
        applyMemOp(OP_LW, 32'h00000003, 32'd0, 5'd7, 0, 32'hCAFEF00D, a, we, st, wd, rc, stable);
        assertCount++;
        if (a !== 16'h0000 || rc != 1) begin
            failCount++;
            $display("[TB] FAIL misalign_truncate: got addr=%h req_cycles=%0d, required 0000 1", a, rc);
        end
        applyMemOp(OP_SH, 32'h00000013, 32'h0000BEEF, 5'd2, 0, 32'h0, a, we, st, wd, rc, stable);
        assertCount++;
        if (st !== 4'b1100 || wd !== 32'hBEEFBEEF || a !== 16'h0010) begin
            failCount++;
            $display("[TB] FAIL misalign_sh: got strb=%b wdata=%h addr=%h, required 1100 BEEFBEEF 0010",
                     st, wd, a);
        end
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        assertCount   = 0;
        failCount     = 0;
        reset         = 1'b1;
        in_valid      = 1'b0;
        in_op         = OP_NONE;
        in_alu_result = 32'd0;
        in_store_data = 32'd0;
        in_rd_addr    = 5'd0;
        mem_ready     = 1'b0;
        mem_rdata     = 32'hDEADBEEF;
        test_reset();
        test_passthrough();
        test_loads();
        test_stores();
        test_back_to_back();
        test_timeout();
        test_reset_mid_access();
        test_misalign();
        repeat (3) @(negedge clk);
        assertCount++;
        if (sb.size() != 0) begin
            failCount++;
            $display("[TB] FAIL drain: got %0d records outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
